// File: rtl/mem_stage.sv
// Memory stage: one outstanding data-bus access with a WAIT timeout.
// Define MEM_STAGE_MISALIGN_EN to trap misaligned loads/stores.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        MEM_V,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  input  logic        MEM_ECALL,
  output logic        V_MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  output logic [7:0]  DMEM_WSTRB,
  input  logic        DMEM_ACK,
  input  logic [63:0] DMEM_RDATA,
  output logic        WB_V,
  output logic        WB_ECALL,
  output logic        WB_BUS_ERR,
  output logic        WB_MISALIGN,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_ALU_RESULT,
  output logic [63:0] WB_MEM_DATA,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        v;
    logic        ecall;
    logic        bus_err;
    logic        misalign;
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] alu;
    logic [63:0] mem_data;
    logic [63:0] csrfd;
    logic [63:0] rfd;
  } wb_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } dm_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  wb_t         wb_q, wb_nx;
  dm_t         dm_q, dm_nx;
  logic [15:0] cnt_q, cnt_nx;

  logic [31:0] c_ir;
  logic [63:0] c_npc, c_addr, c_csrfd, c_rfd;
  logic        c_ecall;

  logic [2:0]  f3, off, c_f3, c_off;
  logic        is_ld, is_st, is_mem, mis_en, issue, tmo;
  logic [7:0]  smask;
  logic [63:0] ld_sh, ld_data;

  assign f3     = MEM_IR[14:12];
  assign off    = MEM_ALU_RESULT[2:0];
  assign is_ld  = MEM_IR[6:0] == 7'b0000011 && f3 != 3'd7;
  assign is_st  = MEM_IR[6:0] == 7'b0100011 && !f3[2];
  assign is_mem = is_ld | is_st;

`ifdef MEM_STAGE_MISALIGN_EN
  always_comb begin
    case (f3[1:0])
      2'd0:    mis_en = 1'b0;
      2'd1:    mis_en = off[0];
      2'd2:    mis_en = |off[1:0];
      default: mis_en = |off;
    endcase
  end
`else
  assign mis_en = 1'b0;
`endif

  assign issue = state == IDLE && MEM_V && is_mem && !mis_en;
  assign tmo   = TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST;

  assign c_f3  = c_ir[14:12];
  assign c_off = c_addr[2:0];
  assign ld_sh = DMEM_RDATA >> {c_off, 3'b000};

  always_comb begin
    case (f3[1:0])
      2'd0:    smask = 8'h01;
      2'd1:    smask = 8'h03;
      2'd2:    smask = 8'h0F;
      default: smask = 8'hFF;
    endcase
  end

  always_comb begin
    case (c_f3)
      3'd0:    ld_data = {{56{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_data = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'd2:    ld_data = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'd4:    ld_data = {56'h0, ld_sh[7:0]};
      3'd5:    ld_data = {48'h0, ld_sh[15:0]};
      3'd6:    ld_data = {32'h0, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

  always_comb begin
    V_MEM_STALL = 1'b0;
    if (RESET_N)
      V_MEM_STALL = (state == IDLE) ? issue : !DMEM_ACK;
  end

  always_comb begin
    state_nx = state;
    wb_nx    = '0;
    dm_nx    = dm_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (issue) begin
          state_nx    = WAIT;
          dm_nx.req   = 1'b1;
          dm_nx.we    = is_st;
          dm_nx.addr  = {MEM_ALU_RESULT[63:3], 3'b000};
          dm_nx.wdata = is_st ? MEM_SR2 << {off, 3'b000} : '0;
          dm_nx.wstrb = is_st ? smask << off : '0;
        end else if (MEM_V) begin
          wb_nx.v        = 1'b1;
          wb_nx.ecall    = MEM_ECALL;
          wb_nx.misalign = is_mem & mis_en;
          wb_nx.ir       = MEM_IR;
          wb_nx.npc      = MEM_NPC;
          wb_nx.alu      = MEM_ALU_RESULT;
          wb_nx.csrfd    = MEM_CSRFD;
          wb_nx.rfd      = MEM_RFD;
        end
      end
      WAIT: begin
        if (DMEM_ACK || tmo) begin
          state_nx      = IDLE;
          dm_nx         = '0;
          cnt_nx        = '0;
          wb_nx.v       = 1'b1;
          wb_nx.ecall   = c_ecall;
          wb_nx.bus_err = !DMEM_ACK;
          wb_nx.ir      = c_ir;
          wb_nx.npc     = c_npc;
          wb_nx.alu     = c_addr;
          wb_nx.csrfd   = c_csrfd;
          wb_nx.rfd     = c_rfd;
          // bit 5 of the opcode separates stores from loads
          if (DMEM_ACK && !c_ir[5])
            wb_nx.mem_data = ld_data;
        end else begin
          cnt_nx = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      wb_q    <= '0;
      dm_q    <= '0;
      cnt_q   <= '0;
      c_ir    <= '0;
      c_npc   <= '0;
      c_addr  <= '0;
      c_csrfd <= '0;
      c_rfd   <= '0;
      c_ecall <= 1'b0;
    end else begin
      state <= state_nx;
      wb_q  <= wb_nx;
      dm_q  <= dm_nx;
      cnt_q <= cnt_nx;
      if (issue) begin
        c_ir    <= MEM_IR;
        c_npc   <= MEM_NPC;
        c_addr  <= MEM_ALU_RESULT;
        c_csrfd <= MEM_CSRFD;
        c_rfd   <= MEM_RFD;
        c_ecall <= MEM_ECALL;
      end
    end
  end

  assign DMEM_REQ      = dm_q.req;
  assign DMEM_WE       = dm_q.we;
  assign DMEM_ADDR     = dm_q.addr;
  assign DMEM_WDATA    = dm_q.wdata;
  assign DMEM_WSTRB    = dm_q.wstrb;
  assign WB_V          = wb_q.v;
  assign WB_ECALL      = wb_q.ecall;
  assign WB_BUS_ERR    = wb_q.bus_err;
  assign WB_MISALIGN   = wb_q.misalign;
  assign WB_IR         = wb_q.ir;
  assign WB_NPC        = wb_q.npc;
  assign WB_ALU_RESULT = wb_q.alu;
  assign WB_MEM_DATA   = wb_q.mem_data;
  assign WB_CSRFD      = wb_q.csrfd;
  assign WB_RFD        = wb_q.rfd;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic
// checked against a byte-level model of the access rules.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
  logic        MEM_ECALL;
  logic        V_MEM_STALL;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_ACK;
  logic [63:0] DMEM_RDATA;
  logic        WB_V, WB_ECALL, WB_BUS_ERR, WB_MISALIGN;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_DATA, WB_CSRFD, WB_RFD;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL),
    .V_MEM_STALL(V_MEM_STALL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .WB_V(WB_V), .WB_ECALL(WB_ECALL), .WB_BUS_ERR(WB_BUS_ERR),
    .WB_MISALIGN(WB_MISALIGN), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_DATA(WB_MEM_DATA),
    .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD)
  );

  wire [355:0] wb_obs = {WB_V, WB_ECALL, WB_BUS_ERR, WB_MISALIGN,
                         WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_DATA,
                         WB_CSRFD, WB_RFD};
  wire [137:0] dm_obs = {DMEM_REQ, DMEM_WE, DMEM_ADDR,
                         DMEM_WDATA, DMEM_WSTRB};

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt, req_cnt;
  logic [137:0] dm_seen;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] mk_ir(logic [6:0] opc, logic [2:0] f3);
    logic [31:0] ir;
    ir = $urandom;
    ir[6:0] = opc;
    ir[14:12] = f3;
    return ir;
  endfunction

  // Gather the accessed bytes one at a time, then extend.
  function automatic logic [63:0] ld_model(logic [2:0] f3,
                                           logic [63:0] addr,
                                           logic [63:0] rd);
    int sz, off;
    logic [63:0] v, ones;
    sz = 1 << f3[1:0];
    off = int'(addr[2:0]);
    v = '0;
    ones = '1;
    for (int i = 0; i < sz; i++)
      if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (ones << (8*sz));
    return v;
  endfunction

  task automatic st_model(input logic [1:0] s, input logic [63:0] addr,
                          input logic [63:0] sr2,
                          output logic [7:0] strb, output logic [63:0] wd);
    int sz, off;
    sz = 1 << s;
    off = int'(addr[2:0]);
    strb = '0;
    wd = '0;
    for (int j = 0; j < 8; j++)
      if (j >= off) begin
        wd[8*j +: 8] = sr2[8*(j-off) +: 8];
        if (j - off < sz) strb[j] = 1'b1;
      end
  endtask

  // Issue one instruction at posedge+1 and follow it to completion.
  task automatic do_op(input logic [31:0] ir, input logic [63:0] addr,
                       input logic [63:0] sr2, input logic [63:0] rd,
                       input int d);
    logic [63:0] npc, csr, rfd, wd, data;
    logic [7:0] strb;
    logic [137:0] exp_dm;
    logic [355:0] exp_wb;
    logic [2:0] f3;
    logic ec;
    bit ld, st, mis, waits, done, ack, tmo;
    npc = r64();
    csr = r64();
    rfd = r64();
    ec = 1'($urandom);
    f3 = ir[14:12];
    ld = ir[6:0] == 7'b0000011 && f3 != 3'd7;
    st = ir[6:0] == 7'b0100011 && f3 < 3'd4;
    mis = 0;
`ifdef MEM_STAGE_MISALIGN_EN
    mis = (ld || st) && (addr % 64'(1 << f3[1:0])) != 0;
`endif
    waits = (ld || st) && !mis;
    done = 0;
    st_model(f3[1:0], addr, sr2, strb, wd);
    if (!st) begin
      strb = '0;
      wd = '0;
    end
    exp_dm = {1'b1, st, addr & ~64'h7, wd, strb};
    stall_cnt = 0;
    req_cnt = 0;
    dm_seen = '0;
    MEM_V = 1'b1;
    MEM_IR = ir;
    MEM_NPC = npc;
    MEM_ALU_RESULT = addr;
    MEM_SR2 = sr2;
    MEM_CSRFD = csr;
    MEM_RFD = rfd;
    MEM_ECALL = ec;
    DMEM_ACK = 1'b0;
    DMEM_RDATA = r64();
    #1;
    n_cmp++;
    if (V_MEM_STALL !== waits) begin
      n_bad++;
      $display("FAIL issue_stall: got %b want %b", V_MEM_STALL, waits);
    end
    if (V_MEM_STALL) stall_cnt++;
    @(posedge clk); #1;
    if (!waits) begin
      exp_wb = {1'b1, ec, 1'b0, mis, ir, npc, addr, 64'h0, csr, rfd};
      n_cmp++;
      if (wb_obs !== exp_wb) begin
        n_bad++;
        $display("FAIL wb_direct: got %h want %h", wb_obs, exp_wb);
      end
      n_cmp++;
      if (DMEM_REQ !== 1'b0) begin
        n_bad++;
        $display("FAIL no_req: got %b want 0", DMEM_REQ);
      end
    end else begin
      MEM_V = 1'($urandom);
      MEM_IR = $urandom;
      MEM_ALU_RESULT = r64();
      MEM_SR2 = r64();
      MEM_ECALL = 1'($urandom);
      for (int k = 0; k < TO + 4 && !done; k++) begin
        ack = (k == d);
        tmo = !ack && (k == TO - 1);
        n_cmp++;
        if (dm_obs !== exp_dm) begin
          n_bad++;
          $display("FAIL dmem_req: got %h want %h", dm_obs, exp_dm);
        end
        n_cmp++;
        if (WB_V !== 1'b0) begin
          n_bad++;
          $display("FAIL wb_wait: got %b want 0", WB_V);
        end
        if (DMEM_REQ) req_cnt++;
        dm_seen = dm_obs;
        DMEM_ACK = ack;
        DMEM_RDATA = ack ? rd : r64();
        #1;
        n_cmp++;
        if (V_MEM_STALL !== !ack) begin
          n_bad++;
          $display("FAIL wait_stall: got %b want %b", V_MEM_STALL, !ack);
        end
        if (V_MEM_STALL) stall_cnt++;
        @(posedge clk); #1;
        DMEM_ACK = 1'b0;
        if (ack || tmo) begin
          done = 1;
          data = (ack && ld) ? ld_model(f3, addr, rd) : 64'h0;
          exp_wb = {1'b1, ec, tmo, 1'b0, ir, npc, addr, data, csr, rfd};
          n_cmp++;
          if (wb_obs !== exp_wb) begin
            n_bad++;
            $display("FAIL wb_mem: got %h want %h", wb_obs, exp_wb);
          end
          n_cmp++;
          if (DMEM_REQ !== 1'b0) begin
            n_bad++;
            $display("FAIL req_drop: got %b want 0", DMEM_REQ);
          end
        end
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_bound: got no completion want one");
      end
    end
    MEM_V = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    MEM_V = 1'b1;
    MEM_IR = mk_ir(7'b0000011, 3'd3);
    MEM_NPC = r64();
    MEM_ALU_RESULT = r64();
    MEM_SR2 = r64();
    MEM_CSRFD = r64();
    MEM_RFD = r64();
    MEM_ECALL = 1'b1;
    DMEM_ACK = 1'b1;
    DMEM_RDATA = r64();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({V_MEM_STALL, dm_obs, wb_obs} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b/%h/%h want 0",
               V_MEM_STALL, dm_obs, wb_obs);
    end
    #3;
    RESET_N = 1'b1;
    MEM_V = 1'b0;
    DMEM_ACK = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    do_op(mk_ir(7'b0110011, 3'($urandom)), 64'h55, r64(), r64(), 0);
    n_cmp++;
    if ({WB_V, WB_ALU_RESULT, 32'(stall_cnt)} !== {1'b1, 64'h55, 32'd0}) begin
      n_bad++;
      $display("FAIL alu_pass: got %b %h %0d want 1 55 0",
               WB_V, WB_ALU_RESULT, stall_cnt);
    end
  endtask

  task automatic test_lb();
    do_op(mk_ir(7'b0000011, 3'd0), 64'h1003, r64(),
          64'h0000000080000000, 3);
    n_cmp++;
    if (dm_seen[135:72] !== 64'h1000) begin
      n_bad++;
      $display("FAIL lb_addr: got %h want 1000", dm_seen[135:72]);
    end
    n_cmp++;
    if (stall_cnt != 4) begin
      n_bad++;
      $display("FAIL lb_stall: got %0d want 4", stall_cnt);
    end
    n_cmp++;
    if (WB_MEM_DATA !== 64'hFFFFFFFFFFFFFF80) begin
      n_bad++;
      $display("FAIL lb_data: got %h want ffffffffffffff80", WB_MEM_DATA);
    end
  endtask

  task automatic test_sh();
    logic [137:0] want;
    want = {1'b1, 1'b1, 64'h2000, 64'h1234000000000000, 8'hC0};
    do_op(mk_ir(7'b0100011, 3'd1), 64'h2006, 64'h1234, r64(), 0);
    n_cmp++;
    if (dm_seen !== want) begin
      n_bad++;
      $display("FAIL sh_bus: got %h want %h", dm_seen, want);
    end
    n_cmp++;
    if ({WB_V, WB_MEM_DATA} !== {1'b1, 64'h0}) begin
      n_bad++;
      $display("FAIL sh_wb: got %b %h want 1 0", WB_V, WB_MEM_DATA);
    end
  endtask

  task automatic test_timeout();
    do_op(mk_ir(7'b0000011, 3'd3), r64() & ~64'h7, r64(), r64(), 20);
    n_cmp++;
    if (req_cnt != TO) begin
      n_bad++;
      $display("FAIL tmo_req_cycles: got %0d want %0d", req_cnt, TO);
    end
    n_cmp++;
    if ({WB_V, WB_BUS_ERR, WB_MEM_DATA} !== {2'b11, 64'h0}) begin
      n_bad++;
      $display("FAIL tmo_wb: got %b%b %h want 11 0",
               WB_V, WB_BUS_ERR, WB_MEM_DATA);
    end
  endtask

  task automatic test_reset_wait();
    MEM_V = 1'b1;
    MEM_IR = mk_ir(7'b0000011, 3'd3);
    MEM_ALU_RESULT = 64'h4000;
    DMEM_ACK = 1'b0;
    @(posedge clk); #1;
    MEM_V = 1'b0;
    n_cmp++;
    if (DMEM_REQ !== 1'b1) begin
      n_bad++;
      $display("FAIL rw_req: got %b want 1", DMEM_REQ);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({V_MEM_STALL, dm_obs, wb_obs} !== '0) begin
      n_bad++;
      $display("FAIL rw_async: got %b/%h/%h want 0",
               V_MEM_STALL, dm_obs, wb_obs);
    end
    #2;
    RESET_N = 1'b1;
    DMEM_ACK = 1'b1;
    DMEM_RDATA = r64();
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({WB_V, DMEM_REQ} !== 2'b00) begin
        n_bad++;
        $display("FAIL rw_ghost: got %b%b want 00", WB_V, DMEM_REQ);
      end
    end
    DMEM_ACK = 1'b0;
  endtask

  task automatic test_misalign();
    do_op(mk_ir(7'b0000011, 3'd2), 64'h3002, r64(), r64(), 0);
`ifdef MEM_STAGE_MISALIGN_EN
    n_cmp++;
    if ({WB_V, WB_MISALIGN, 32'(req_cnt)} !== {2'b11, 32'd0}) begin
      n_bad++;
      $display("FAIL lw_misalign: got %b%b %0d want 11 0",
               WB_V, WB_MISALIGN, req_cnt);
    end
`else
    n_cmp++;
    if ({WB_V, WB_MISALIGN, dm_seen[135:72]} !== {2'b10, 64'h3000}) begin
      n_bad++;
      $display("FAIL lw_unaligned: got %b%b %h want 10 3000",
               WB_V, WB_MISALIGN, dm_seen[135:72]);
    end
`endif
  endtask

  task automatic test_bubble();
    do_op(mk_ir(7'b0010011, 3'd0), r64(), r64(), r64(), 0);
    MEM_V = 1'b0;
    DMEM_ACK = 1'b1;
    @(posedge clk); #1;
    DMEM_ACK = 1'b0;
    n_cmp++;
    if ({wb_obs, DMEM_REQ} !== '0) begin
      n_bad++;
      $display("FAIL bubble: got %h %b want 0", wb_obs, DMEM_REQ);
    end
  endtask

  task automatic test_random();
    logic [6:0] alu_opc [5];
    logic [31:0] ir;
    alu_opc = '{7'b0110011, 7'b0010011, 7'b0110111,
                7'b1101111, 7'b1110011};
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: ir = mk_ir(alu_opc[$urandom_range(0, 4)], 3'($urandom));
        1, 2: ir = mk_ir(7'b0000011, 3'($urandom_range(0, 6)));
        default: ir = mk_ir(7'b0100011, 3'($urandom_range(0, 3)));
      endcase
      do_op(ir, r64(), r64(), r64(), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 4) == 0) begin
        DMEM_ACK = 1'($urandom);
        @(posedge clk); #1;
        DMEM_ACK = 1'b0;
        n_cmp++;
        if ({wb_obs, DMEM_REQ} !== '0) begin
          n_bad++;
          $display("FAIL rnd_bubble: got %h %b want 0", wb_obs, DMEM_REQ);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_timeout();
    test_misalign();
    test_bubble();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
